data_memory_controller: RTL
===========================

# data_memory_controller

Sequential memory-access stage that sits directly upstream of the data-memory load aligner/extender in the MEM stage. It accepts one load or store per request from the pipeline, checks alignment, generates the word address, byte strobes and lane-replicated store data, runs a valid/ready request and read-return handshake with a variable-latency data memory, and stalls the pipeline until the access completes. For loads it presents the raw 32-bit memory word together with the captured offset, size and sign-control bits that the load aligner consumes.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before abort; 0 disables the timeout.
- clock_in  input  1  clock; all state changes on the rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- req_in  input  1  access request; sampled only in IDLE or DONE.
- write_in  input  1  1 = store, 0 = load.
- addr_in  input  32  byte address.
- wdata_in  input  32  store data, right-justified.
- size_in  input  2  access size: 2'b11 word, 2'b01 half, 2'b00 byte, 2'b10 reserved.
- signed_in  input  1  extension control, passed through untouched: 0 = sign-extend, 1 = zero-extend.
- stall_out  output  1  pipeline freeze, combinational.
- done_out  output  1  one-cycle completion pulse.
- error_out  output  1  qualifies done_out: misaligned/reserved-size request or timeout.
- rdata_out  output  32  raw load word, valid while done_out=1.
- offset_out  output  2  captured addr_in[1:0].
- size_out  output  2  captured size_in.
- signed_out  output  1  captured signed_in.
- mem_valid_out  output  1  request valid toward memory.
- mem_ready_in  input  1  memory accepts the request.
- mem_write_out  output  1  request is a store.
- mem_addr_out  output  32  {addr[31:2], 2'b00}.
- mem_wdata_out  output  32  lane-replicated store data.
- mem_strobe_out  output  4  byte-lane enables.
- mem_rvalid_in  input  1  read data valid.
- mem_rdata_in  input  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset: IDLE; all registered outputs 0; timeout counter 0.
- Sampling states are IDLE and DONE. In either, req_in=1 captures write, addr, wdata, size and signed on the rising edge.
- Alignment error: size 2'b10, half with addr[0]=1, or word with addr[1:0]≠0. The request goes to DONE with done_out=1 and error_out=1. No memory transaction is issued.
- Valid request goes to REQ. While in REQ:
  - mem_valid_out=1; address, strobe, wdata and write are held stable until accepted.
  - mem_valid_out=1 and mem_ready_in=1 accepts the request. A store then goes to DONE; a load goes to WAIT.
- WAIT: mem_rvalid_in=1 captures mem_rdata_in into rdata_out and goes to DONE. mem_rvalid_in is ignored in every other state.
- DONE: done_out=1 for this cycle only. Next state:
  - req_in=1 and aligned: REQ.
  - req_in=1 and misaligned: DONE again with error.
  - otherwise: IDLE.
- Strobes:
  - byte: 4'b0001 << offset.
  - half: 4'b0011 if offset=0, 4'b1100 if offset=2.
  - word: 4'b1111.
  - Strobes are also driven for loads.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata unchanged.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the counter equals TIMEOUT_CYCLES (nonzero), the next state is DONE with error_out=1 and rdata_out=0; mem_valid_out drops.
- stall_out = (state∈{REQ,WAIT}) | (state∈{IDLE,DONE} & req_in).
- Reset mid-transaction: immediate return to IDLE with all outputs 0; any in-flight memory response is discarded.

## Timing
- All outputs except stall_out are registered.
- Cycle 0: request sampled. Cycle 1: REQ, with mem_valid_out=1.
- Minimum store latency: done_out in cycle 2, with ready=1 in cycle 1.
- Minimum load latency: rvalid=1 in cycle 2, done_out in cycle 3.
- Each mem_ready_in=0 cycle or each missing rvalid cycle adds one cycle.
- Misaligned request: done_out+error_out in cycle 1.
- Back-to-back: a request presented during DONE starts REQ the next cycle, with no IDLE bubble.
- offset_out, size_out and signed_out update at capture and hold until the next capture.

## Test plan
- Byte store to addr 0x1003, wdata 0xAB, ready=1 immediately -> cycle 1: mem_addr 0x1000, strobe 4'b1000, wdata 0xABABABAB; done_out in cycle 2, error_out=0.
- Half load from 0x2002, signed_in=0, ready after 2 wait cycles, rdata 0x8001_1234 two cycles after accept -> done_out with rdata_out 0x80011234, offset_out 2, size_out 01, signed_out 0; stall_out high from cycle 0 until DONE.
- Word load from 0x3001 -> done_out and error_out in cycle 1; mem_valid_out never asserted. Repeat with size 2'b10 for the same result.
- Store then load presented during DONE -> second REQ begins the cycle after DONE, with no IDLE cycle between.
- TIMEOUT_CYCLES=4, mem_ready_in held 0 -> done_out with error_out after 4 REQ cycles; mem_valid_out=0 afterwards.
- reset_in asserted while in WAIT, then rvalid arrives -> all outputs 0 immediately, state IDLE, the late rvalid ignored, no done_out.

Source files
------------

// File: rtl/data_memory_controller.sv
// MEM-stage data memory access controller: alignment check, strobe/lane generation and a
// valid/ready request plus read-return handshake, stalling the pipeline until completion.
module data_memory_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic        req_in,
   input  logic        write_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   input  logic [1:0]  size_in,
   input  logic        signed_in,
   output logic        stall_out,
   output logic        done_out,
   output logic        error_out,
   output logic [31:0] rdata_out,
   output logic [1:0]  offset_out,
   output logic [1:0]  size_out,
   output logic        signed_out,
   output logic        mem_valid_out,
   input  logic        mem_ready_in,
   output logic        mem_write_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_wdata_out,
   output logic [3:0]  mem_strobe_out,
   input  logic        mem_rvalid_in,
   input  logic [31:0] mem_rdata_in
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] count_q, count_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  offset_q, offset_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic        mem_valid_q, mem_valid_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_strobe_q, mem_strobe_d;

   logic        misaligned;
   logic [3:0]  req_strobe;
   logic [31:0] req_wdata;
   logic        timeout_hit;
   logic        sampling;

   // Decode the incoming request: alignment, byte lanes and replicated store data.
   always_comb begin
      misaligned = 1'b0;
      req_strobe = 4'b0000;
      req_wdata  = wdata_in;
      unique case (size_in)
         2'b00: begin
            req_strobe = 4'b0001 << addr_in[1:0];
            req_wdata  = {4{wdata_in[7:0]}};
         end
         2'b01: begin
            misaligned = addr_in[0];
            req_strobe = addr_in[1] ? 4'b1100 : 4'b0011;
            req_wdata  = {2{wdata_in[15:0]}};
         end
         2'b11: begin
            misaligned = |addr_in[1:0];
            req_strobe = 4'b1111;
         end
         default: misaligned = 1'b1;
      endcase
   end

   // Fires on the last permitted REQ/WAIT cycle, so at most TIMEOUT_CYCLES are spent there.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q >= (TIMEOUT_CYCLES - 32'd1));
   assign sampling    = (state_q == StIdle) || (state_q == StDone);
   assign stall_out   = (state_q == StReq) || (state_q == StWait) || (sampling && req_in);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      done_d       = 1'b0;
      error_d      = 1'b0;
      rdata_d      = 32'd0;
      offset_d     = offset_q;
      size_d       = size_q;
      signed_d     = signed_q;
      mem_valid_d  = 1'b0;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_strobe_d = mem_strobe_q;
      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (req_in) begin
               offset_d = addr_in[1:0];
               size_d   = size_in;
               signed_d = signed_in;
               if (misaligned) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else begin
                  state_d      = StReq;
                  count_d      = 32'd0;
                  mem_valid_d  = 1'b1;
                  mem_write_d  = write_in;
                  mem_addr_d   = {addr_in[31:2], 2'b00};
                  mem_wdata_d  = req_wdata;
                  mem_strobe_d = req_strobe;
               end
            end
         end
         StReq: begin
            count_d = count_q + 32'd1;
            if (mem_ready_in) begin
               if (mem_write_q) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end else if (timeout_hit) begin
               state_d = StDone;
               done_d  = 1'b1;
               error_d = 1'b1;
            end else begin
               mem_valid_d = 1'b1;
            end
         end
         StWait: begin
            count_d = count_q + 32'd1;
            if (mem_rvalid_in) begin
               state_d = StDone;
               done_d  = 1'b1;
               rdata_d = mem_rdata_in;
            end else if (timeout_hit) begin
               state_d = StDone;
               done_d  = 1'b1;
               error_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q      <= StIdle;
         count_q      <= 32'd0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         rdata_q      <= 32'd0;
         offset_q     <= 2'b00;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         mem_valid_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         mem_strobe_q <= 4'b0000;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         done_q       <= done_d;
         error_q      <= error_d;
         rdata_q      <= rdata_d;
         offset_q     <= offset_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         mem_valid_q  <= mem_valid_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_strobe_q <= mem_strobe_d;
      end
   end

   assign done_out       = done_q;
   assign error_out      = error_q;
   assign rdata_out      = rdata_q;
   assign offset_out     = offset_q;
   assign size_out       = size_q;
   assign signed_out     = signed_q;
   assign mem_valid_out  = mem_valid_q;
   assign mem_write_out  = mem_write_q;
   assign mem_addr_out   = mem_addr_q;
   assign mem_wdata_out  = mem_wdata_q;
   assign mem_strobe_out = mem_strobe_q;

endmodule
